// File: rtl/scbuf_fbctl.sv
// Fill-buffer control: 8-entry IDLE/ALLOC/FILL/FULL tracking, fill/store write arbitration, read checks.
// Optional SCBUF_FBCTL_PERF_CNT_EN adds a saturating st_stall_c2 cycle counter (st_stall_cnt).
module scbuf_fbctl (
  input  logic        rclk,
  input  logic        arst_l,
  input  logic        alloc_req_c2,
  output logic        alloc_gnt_c3,
  output logic [2:0]  alloc_id_c3,
  output logic        fb_full,
  input  logic        dram_fill_vld_r1,
  input  logic [2:0]  dram_fill_id_r1,
  input  logic        st_req_c2,
  input  logic [2:0]  st_id_c2,
  input  logic [15:0] st_wen_c2,
  output logic        st_stall_c2,
  input  logic        rd_req_c2,
  input  logic [2:0]  rd_id_c2,
  input  logic        dealloc_vld,
  input  logic [2:0]  dealloc_id,
  output logic [15:0] sctag_scbuf_fbwr_wen_r2,
  output logic [2:0]  sctag_scbuf_fbwr_wl_r2,
  output logic        sctag_scbuf_fbd_stdatasel_c3,
  output logic        sctag_scbuf_fbrd_en_c3,
  output logic [2:0]  sctag_scbuf_fbrd_wl_c3,
  output logic        fill_done_r2,
  output logic [2:0]  fill_done_id_r2,
`ifdef SCBUF_FBCTL_PERF_CNT_EN
  output logic [15:0] st_stall_cnt,
`endif
  output logic        rd_err_c3
);

  typedef enum logic [1:0] {S_IDLE, S_ALLOC, S_FILL, S_FULL} ent_state_e;

  logic [7:0]  idle_vec;
  logic [7:0]  full_vec;
  logic [2:0]  alloc_sel;
  logic        alloc_ok, fill_ok, fill_last, st_ok, rd_ok;
  logic [1:0]  beat_cnt_reg, beat_cnt_next;
  logic [2:0]  fill_id_reg, fill_id_next;

  assign fb_full     = ~|idle_vec;
  assign st_stall_c2 = arst_l & st_req_c2 & dram_fill_vld_r1;
  assign alloc_ok    = alloc_req_c2 & ~fb_full;
  assign fill_ok     = dram_fill_vld_r1 & ~idle_vec[dram_fill_id_r1];
  assign fill_last   = fill_ok & (beat_cnt_reg == 2'd3);
  assign st_ok       = st_req_c2 & ~dram_fill_vld_r1 & ~idle_vec[st_id_c2];
  assign rd_ok       = rd_req_c2 & full_vec[rd_id_c2];

  // Lowest-numbered IDLE entry; descending scan so the smallest index wins.
  always_comb begin
    alloc_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (idle_vec[i]) alloc_sel = 3'(i);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ent
      ent_state_e state_reg, state_next;

      // Dealloc is applied last so it overrides alloc/fill updates to the same entry.
      always_comb begin
        state_next = state_reg;
        if (alloc_ok && alloc_sel == 3'(gi)) state_next = S_ALLOC;
        if (fill_ok && dram_fill_id_r1 == 3'(gi)) state_next = fill_last ? S_FULL : S_FILL;
        if (dealloc_vld && dealloc_id == 3'(gi)) state_next = S_IDLE;
      end

      always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) state_reg <= S_IDLE;
        else         state_reg <= state_next;
      end

      assign idle_vec[gi] = (state_reg == S_IDLE);
      assign full_vec[gi] = (state_reg == S_FULL);
    end
  endgenerate

  // Single in-flight fill: beat counter clears if its entry is freed.
  always_comb begin
    beat_cnt_next = beat_cnt_reg;
    fill_id_next  = fill_id_reg;
    if (fill_ok) begin
      beat_cnt_next = beat_cnt_reg + 2'd1;
      fill_id_next  = dram_fill_id_r1;
    end
    if (dealloc_vld && dealloc_id == fill_id_next && (fill_ok || beat_cnt_reg != 2'd0))
      beat_cnt_next = 2'd0;
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      beat_cnt_reg <= 2'd0;
      fill_id_reg  <= 3'd0;
    end else begin
      beat_cnt_reg <= beat_cnt_next;
      fill_id_reg  <= fill_id_next;
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      alloc_gnt_c3                 <= 1'b0;
      alloc_id_c3                  <= 3'd0;
      sctag_scbuf_fbwr_wen_r2      <= 16'h0;
      sctag_scbuf_fbwr_wl_r2       <= 3'd0;
      sctag_scbuf_fbd_stdatasel_c3 <= 1'b0;
      sctag_scbuf_fbrd_en_c3       <= 1'b0;
      sctag_scbuf_fbrd_wl_c3       <= 3'd0;
      fill_done_r2                 <= 1'b0;
      fill_done_id_r2              <= 3'd0;
      rd_err_c3                    <= 1'b0;
    end else begin
      alloc_gnt_c3                 <= alloc_ok;
      alloc_id_c3                  <= alloc_ok ? alloc_sel : 3'd0;
      if (fill_ok) begin
        sctag_scbuf_fbwr_wen_r2    <= 16'hF << {beat_cnt_reg, 2'b00};
        sctag_scbuf_fbwr_wl_r2     <= dram_fill_id_r1;
      end else if (st_ok) begin
        sctag_scbuf_fbwr_wen_r2    <= st_wen_c2;
        sctag_scbuf_fbwr_wl_r2     <= st_id_c2;
      end else begin
        sctag_scbuf_fbwr_wen_r2    <= 16'h0;
        sctag_scbuf_fbwr_wl_r2     <= 3'd0;
      end
      sctag_scbuf_fbd_stdatasel_c3 <= st_ok;
      sctag_scbuf_fbrd_en_c3       <= rd_ok;
      sctag_scbuf_fbrd_wl_c3       <= rd_ok ? rd_id_c2 : 3'd0;
      fill_done_r2                 <= fill_last;
      fill_done_id_r2              <= fill_last ? dram_fill_id_r1 : 3'd0;
      rd_err_c3                    <= rd_req_c2 & ~rd_ok;
    end
  end

`ifdef SCBUF_FBCTL_PERF_CNT_EN
  logic [15:0] stall_cnt_reg;
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l)                                      stall_cnt_reg <= 16'h0;
    else if (st_stall_c2 && stall_cnt_reg != 16'hFFFF) stall_cnt_reg <= stall_cnt_reg + 16'h1;
  end
  assign st_stall_cnt = stall_cnt_reg;
`endif

endmodule
